// File: rtl/apb_top.sv
// rtl/apb_top.sv - APB master bridge with two zero-wait-state completer memories
module apb_mem #(
    parameter int DEPTH = 32,
    parameter int AW    = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          psel,
    input  logic          penable,
    input  logic          pwrite,
    input  logic [AW-1:0] index,
    input  logic [31:0]   pwdata,
    output logic [31:0]   prdata,
    output logic          pready
);

    logic [31:0] mem [DEPTH];

    // Storage: cleared on reset, written in the cycle that ends a write ACCESS
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (psel && penable && pwrite) begin
            mem[index] <= pwdata;
        end
    end

    // Zero wait states: ready as soon as the access phase is reached
    always_comb begin
        pready = psel && penable;
        prdata = psel ? mem[index] : '0;
    end

endmodule

module apb_top #(
    parameter int MEM_DEPTH = 32
) (
    input  logic        PCLK,
    input  logic        PRESETn,
    input  logic        Transfer,
    input  logic        Wr_Rd,
    input  logic [32:0] Address,
    input  logic [31:0] write_data,
    output logic [31:0] read_data
);

    localparam int AW = $clog2(MEM_DEPTH);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    state_t      state;
    state_t      state_next;
    logic        load;

    logic [32:0] req_addr;
    logic        req_write;
    logic [31:0] req_wdata;

    logic        psel1;
    logic        psel2;
    logic        penable;
    logic        pwrite;
    logic [31:0] paddr;
    logic [31:0] pwdata;
    logic [31:0] prdata;
    logic [31:0] prdata1;
    logic [31:0] prdata2;
    logic        pready;
    logic        pready1;
    logic        pready2;
    logic        unused_paddr_bits;

    assign paddr  = req_addr[31:0];
    assign pwrite = req_write;
    assign pwdata = req_wdata;

    // Completers only decode the word index; the upper address bits are forwarded but ignored
    assign unused_paddr_bits = ^paddr[31:AW];

    // State register
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next state, request capture strobe and bus control
    always_comb begin
        state_next = state;
        load       = 1'b0;
        psel1      = 1'b0;
        psel2      = 1'b0;
        penable    = 1'b0;
        case (state)
            IDLE: begin
                if (Transfer) begin
                    state_next = SETUP;
                    load       = 1'b1;
                end
            end
            SETUP: begin
                psel1      = !req_addr[32];
                psel2      = req_addr[32];
                state_next = ACCESS;
            end
            ACCESS: begin
                psel1   = !req_addr[32];
                psel2   = req_addr[32];
                penable = 1'b1;
                if (pready) begin
                    if (Transfer) begin
                        state_next = SETUP;
                        load       = 1'b1;
                    end else begin
                        state_next = IDLE;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Request registers: inputs are only sampled on the edge that enters SETUP
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            req_addr  <= '0;
            req_write <= 1'b0;
            req_wdata <= '0;
        end else if (load) begin
            req_addr  <= Address;
            req_write <= Wr_Rd;
            req_wdata <= write_data;
        end
    end

    // Read data capture at the edge that completes a read ACCESS; held otherwise
    always_ff @(posedge PCLK) begin
        if (PRESETn) begin
            read_data <= '0;
        end else if (state == ACCESS && pready && !req_write) begin
            read_data <= prdata;
        end
    end

    assign prdata = psel2 ? prdata2 : prdata1;
    assign pready = psel2 ? pready2 : pready1;

    apb_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_slave1 (
        .clk     (PCLK),
        .rst     (PRESETn),
        .psel    (psel1),
        .penable (penable),
        .pwrite  (pwrite),
        .index   (paddr[AW-1:0]),
        .pwdata  (pwdata),
        .prdata  (prdata1),
        .pready  (pready1)
    );

    apb_mem #(.DEPTH(MEM_DEPTH), .AW(AW)) u_slave2 (
        .clk     (PCLK),
        .rst     (PRESETn),
        .psel    (psel2),
        .penable (penable),
        .pwrite  (pwrite),
        .index   (paddr[AW-1:0]),
        .pwdata  (pwdata),
        .prdata  (prdata2),
        .pready  (pready2)
    );

endmodule

// File: tb/tb_apb_top.sv
// tb/tb_apb_top.sv - directed table-driven bench for apb_top
module tb_apb_top;

    logic        PCLK = 1'b0;
    logic        PRESETn;
    logic        Transfer;
    logic        Wr_Rd;
    logic [32:0] Address;
    logic [31:0] write_data;
    logic [31:0] read_data;

    int total = 0;
    int bad   = 0;

    typedef struct {
        logic        wr;
        logic [32:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rd;
    } vec_t;

    vec_t single_v [11];
    vec_t b2b_v [6];

    apb_top #(.MEM_DEPTH(32)) dut (
        .PCLK       (PCLK),
        .PRESETn    (PRESETn),
        .Transfer   (Transfer),
        .Wr_Rd      (Wr_Rd),
        .Address    (Address),
        .write_data (write_data),
        .read_data  (read_data)
    );

    always #5 PCLK = ~PCLK;

    task automatic step();
        @(posedge PCLK);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] bus_phase();
        return {29'd0, dut.psel1, dut.psel2, dut.penable};
    endfunction

    function automatic logic [31:0] exp_phase(input logic [32:0] addr, input logic acc);
        return {29'd0, !addr[32], addr[32], acc};
    endfunction

    task automatic drive(input logic tr, input logic wr, input logic [32:0] addr, input logic [31:0] wd);
        Transfer   = tr;
        Wr_Rd      = wr;
        Address    = addr;
        write_data = wd;
    endtask

    // Single transfer: Transfer dropped during SETUP, then returns to IDLE
    task automatic do_xfer(input logic wr, input logic [32:0] addr, input logic [31:0] wd);
        drive(1'b1, wr, addr, wd);
        step();
        drive(1'b0, ~wr, ~addr, ~wd);
        step();
        step();
    endtask

    initial begin
        single_v[0]  = '{1'b0, 33'h0_00000000, 32'h0,        32'h0};
        single_v[1]  = '{1'b1, 33'h0_00000012, 32'hDEADBEEF, 32'h0};
        single_v[2]  = '{1'b0, 33'h0_00000012, 32'h0,        32'hDEADBEEF};
        single_v[3]  = '{1'b1, 33'h0_00000003, 32'h11111111, 32'hDEADBEEF};
        single_v[4]  = '{1'b1, 33'h1_00000003, 32'h22222222, 32'hDEADBEEF};
        single_v[5]  = '{1'b0, 33'h0_00000003, 32'h0,        32'h11111111};
        single_v[6]  = '{1'b0, 33'h1_00000003, 32'h0,        32'h22222222};
        single_v[7]  = '{1'b0, 33'h1_00000012, 32'h0,        32'h0};
        single_v[8]  = '{1'b0, 33'h0_FFFFFFE3, 32'h0,        32'h11111111};
        single_v[9]  = '{1'b1, 33'h0_0000001F, 32'hA5A5A5A5, 32'h11111111};
        single_v[10] = '{1'b0, 33'h0_0000001F, 32'h0,        32'hA5A5A5A5};

        b2b_v[0] = '{1'b1, 33'h0_00000012, 32'hDEADBEEF, 32'h0};
        b2b_v[1] = '{1'b1, 33'h0_00000015, 32'hDABBCAFE, 32'h0};
        b2b_v[2] = '{1'b0, 33'h0_00000012, 32'h0,        32'hDEADBEEF};
        b2b_v[3] = '{1'b0, 33'h0_00000015, 32'h0,        32'hDABBCAFE};
        b2b_v[4] = '{1'b1, 33'h1_00000007, 32'h0BADF00D, 32'hDABBCAFE};
        b2b_v[5] = '{1'b0, 33'h1_00000007, 32'h0,        32'h0BADF00D};

        PRESETn = 1'b1;
        drive(1'b0, 1'b0, '0, '0);
        step();
        step();
        PRESETn = 1'b0;
        check("reset_read_data", read_data, 32'h0);
        check("reset_bus_idle", bus_phase(), 32'h0);

        for (int i = 0; i < 11; i++) begin
            do_xfer(single_v[i].wr, single_v[i].addr, single_v[i].wdata);
            check($sformatf("vec%0d_read_data", i), read_data, single_v[i].exp_rd);
            check($sformatf("vec%0d_idle", i), bus_phase(), 32'h0);
        end

        // Exact read latency: valid only after the second edge past SETUP entry
        drive(1'b1, 1'b0, 33'h0_00000012, 32'h0);
        step();
        drive(1'b0, 1'b1, 33'h1_0000001F, 32'hFFFFFFFF);
        check("lat_setup_phase", bus_phase(), 32'b100);
        check("lat_setup_rd", read_data, 32'hA5A5A5A5);
        step();
        check("lat_access_phase", bus_phase(), 32'b101);
        check("lat_access_rd", read_data, 32'hA5A5A5A5);
        step();
        check("lat_done_rd", read_data, 32'hDEADBEEF);

        // Back-to-back with Transfer held high, starting from a clean reset
        PRESETn = 1'b1;
        step();
        PRESETn = 1'b0;
        drive(1'b1, b2b_v[0].wr, b2b_v[0].addr, b2b_v[0].wdata);
        step();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("b2b%0d_setup", i), bus_phase(), exp_phase(b2b_v[i].addr, 1'b0));
            check($sformatf("b2b%0d_prev_rd", i), read_data, (i == 0) ? 32'h0 : b2b_v[i-1].exp_rd);
            if (i < 5) begin
                drive(1'b1, b2b_v[i+1].wr, b2b_v[i+1].addr, b2b_v[i+1].wdata);
            end else begin
                drive(1'b1, 1'b1, 33'h1_00000007, 32'hFFFFFFFF);
            end
            step();
            check($sformatf("b2b%0d_access", i), bus_phase(), exp_phase(b2b_v[i].addr, 1'b1));
            if (i == 5) begin
                Transfer = 1'b0;
            end
            step();
        end

        // Transfer dropped during ACCESS: back to IDLE, read_data held
        check("idle_bus", bus_phase(), 32'h0);
        check("idle_rd", read_data, 32'h0BADF00D);
        step();
        step();
        check("idle_bus_hold", bus_phase(), 32'h0);
        check("idle_rd_hold", read_data, 32'h0BADF00D);

        // Reset during SETUP of a write aborts it
        drive(1'b1, 1'b1, 33'h0_00000005, 32'hCAFEF00D);
        step();
        check("abort_setup", bus_phase(), 32'b100);
        PRESETn  = 1'b1;
        Transfer = 1'b0;
        step();
        PRESETn = 1'b0;
        check("abort_bus_idle", bus_phase(), 32'h0);
        check("abort_rd_cleared", read_data, 32'h0);
        step();
        do_xfer(1'b0, 33'h0_00000005, 32'h0);
        check("abort_mem_zero", read_data, 32'h0);
        do_xfer(1'b0, 33'h0_00000012, 32'h0);
        check("reset_cleared_mem", read_data, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
